arbitro_rr_destino: RTL

- Round-robin arbiter/router between four input FIFOs (P0..P3) and four output FIFOs (P0..P3) of the transaction layer.
- Each cycle it grants at most one input head word. It pops that word and pushes it into the output FIFO selected by the word's destination field.
- It skips inputs whose destination output FIFO is almost full, so a blocked input does not stall the others.
- It sits between the input FIFO bank and the output FIFO bank and owns the single shared crossbar path.

---
 rtl/arbitro_rr_destino_if.sv | 30 +++
 rtl/arbitro_rr_destino.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_destino_if.sv
// Bundle between the arbiter, the input FIFO bank and the output FIFO bank.
// slave: arbiter side. master: FIFO-bank side, which drives status and head words.
interface arbitro_rr_destino_if #(
  parameter int unsigned FIFO_WORD_SIZE = 10
);
  logic                      empty_p0, empty_p1, empty_p2, empty_p3;
  logic [FIFO_WORD_SIZE-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic                      almostfull_p0, almostfull_p1, almostfull_p2, almostfull_p3;
  logic                      pop_p0, pop_p1, pop_p2, pop_p3;
  logic                      push_p0, push_p1, push_p2, push_p3;
  logic [FIFO_WORD_SIZE-1:0] data_out_0, data_out_1, data_out_2, data_out_3;

  modport slave (
    input  empty_p0, empty_p1, empty_p2, empty_p3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  almostfull_p0, almostfull_p1, almostfull_p2, almostfull_p3,
    output pop_p0, pop_p1, pop_p2, pop_p3,
    output push_p0, push_p1, push_p2, push_p3,
    output data_out_0, data_out_1, data_out_2, data_out_3
  );

  modport master (
    output empty_p0, empty_p1, empty_p2, empty_p3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output almostfull_p0, almostfull_p1, almostfull_p2, almostfull_p3,
    input  pop_p0, pop_p1, pop_p2, pop_p3,
    input  push_p0, push_p1, push_p2, push_p3,
    input  data_out_0, data_out_1, data_out_2, data_out_3
  );
endinterface

// File: rtl/arbitro_rr_destino.sv
// Round-robin arbiter/router: four input FIFOs -> four output FIFOs over one
// shared crossbar path. The two MSBs of each word select the output FIFO.
// Inputs whose destination is almost full are skipped.
// Optional macro ARB_STATS_EN: per-output saturating 8-bit push counters on
// pkt_count; without it pkt_count is tied to zero.
module arbitro_rr_destino #(
  parameter int unsigned FIFO_WORD_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   reset_L,
  arbitro_rr_destino_if.slave    bus,
  output logic [1:0]             estado,
  output logic [31:0]            pkt_count
);

  localparam int unsigned W = FIFO_WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } estado_t;

  estado_t        state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [3:0]     push_q, push_d;
  logic [W-1:0]   dout_q [4];
  logic [W-1:0]   dout_d [4];

  logic [3:0]     empty, afull, elig;
  logic [W-1:0]   din  [4];
  logic [1:0]     dest [4];
  logic           found;
  logic [1:0]     g;

  // Gather per-port inputs and work out which inputs may be served
  always_comb begin
    empty = {bus.empty_p3, bus.empty_p2, bus.empty_p1, bus.empty_p0};
    afull = {bus.almostfull_p3, bus.almostfull_p2, bus.almostfull_p1, bus.almostfull_p0};
    din[0] = bus.data_in_0;
    din[1] = bus.data_in_1;
    din[2] = bus.data_in_2;
    din[3] = bus.data_in_3;
    for (int unsigned i = 0; i < 4; i++) begin
      dest[i] = din[i][W-1:W-2];
      elig[i] = !empty[i] && !afull[dest[i]];
    end
  end

  // Round-robin search starting at ptr; first eligible input wins
  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

  // Datapath next state: route the granted word, advance the pointer past it
  always_comb begin
    ptr_d  = ptr_q;
    push_d = '0;
    for (int unsigned d = 0; d < 4; d++) dout_d[d] = dout_q[d];
    if (found) begin
      push_d[dest[g]] = 1'b1;
      dout_d[dest[g]] = din[g];
      ptr_d           = g + 2'd1;
    end
  end

  // Datapath registers; reset also discards a grant present in the reset cycle
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ptr_q  <= '0;
      push_q <= '0;
      for (int unsigned d = 0; d < 4; d++) dout_q[d] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      push_q <= push_d;
      for (int unsigned d = 0; d < 4; d++) dout_q[d] <= dout_d[d];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: classify the current cycle
  always_comb begin
    state_d = IDLE;
    if (found)        state_d = ACTIVE;
    else if (~&empty) state_d = STALL;
  end

  // Outputs: combinational pops, registered pushes/data, registered state
  always_comb begin
    logic [3:0] pop;
    pop = (found && reset_L) ? (4'b0001 << g) : '0;
    bus.pop_p0     = pop[0];
    bus.pop_p1     = pop[1];
    bus.pop_p2     = pop[2];
    bus.pop_p3     = pop[3];
    bus.push_p0    = push_q[0];
    bus.push_p1    = push_q[1];
    bus.push_p2    = push_q[2];
    bus.push_p3    = push_q[3];
    bus.data_out_0 = dout_q[0];
    bus.data_out_1 = dout_q[1];
    bus.data_out_2 = dout_q[2];
    bus.data_out_3 = dout_q[3];
    estado         = state_q;
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Counters follow push_d so they step on the same edge the push registers
  always_comb begin
    for (int unsigned d = 0; d < 4; d++) begin
      cnt_d[d] = cnt_q[d];
      if (push_d[d] && cnt_q[d] != 8'hFF) cnt_d[d] = cnt_q[d] + 8'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset_L) for (int unsigned d = 0; d < 4; d++) cnt_q[d] <= '0;
    else          for (int unsigned d = 0; d < 4; d++) cnt_q[d] <= cnt_d[d];
  end

  assign pkt_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign pkt_count = '0;
`endif

endmodule
